// File: rtl/ov7670_sccb_config_if.sv
// Bus bundle between the OV7670 SCCB register loader and its surroundings.
// The master side is the loader; the slave side issues go and watches the SCCB lines and status.
interface ov7670_sccb_config_if;
  logic go;
  logic sio_c;
  logic sio_d_oe;
  logic busy;
  logic done;

  modport master (input go, output sio_c, output sio_d_oe, output busy, output done);
  modport slave  (output go, input sio_c, input sio_d_oe, input busy, input done);
endinterface

// File: rtl/ov7670_sccb_config.sv
// OV7670 SCCB register loader: after a go pulse, writes a ROM of {sub-addr, data} pairs as 3-phase SCCB writes.
// Define OV7670_QCIF_EN to load the RGB QCIF table (7 entries) instead of the default VGA table (6 entries).
module ov7670_sccb_config #(
  parameter int         CLK_DIV    = 60,
  parameter logic [7:0] SLAVE_ID   = 8'h42,
  parameter int         RESET_WAIT = 24000
) (
  input logic                   clk_24,
  input logic                   reset,
  ov7670_sccb_config_if.master  bus
);

`ifdef OV7670_QCIF_EN
  localparam int NUM_ENTRIES = 7;
`else
  localparam int NUM_ENTRIES = 6;
`endif
  localparam int CNT_MAX = (RESET_WAIT > CLK_DIV) ? RESET_WAIT : CLK_DIV;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [2:0]    LAST_ENTRY = 3'(NUM_ENTRIES - 1);
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(RESET_WAIT - 1);

  typedef enum logic [2:0] {IDLE, START, BITS, STOP, GAP, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    qtr, qtr_nxt;
  logic [1:0]    phase, phase_nxt;
  logic [3:0]    pos, pos_nxt;
  logic [2:0]    entry, entry_nxt;
  logic [15:0]   rom_word;
  logic [7:0]    cur_byte;
  logic [2:0]    bit_sel;
  logic          tick;
  logic          sio_c_nxt, oe_nxt;
  logic          sio_c_q, oe_q, busy_q, done_q;

  always_comb begin
    rom_word = 16'h0000;
    case (entry)
      3'd0: rom_word = 16'h1280;
      3'd1: rom_word = 16'h1101;
`ifdef OV7670_QCIF_EN
      3'd2: rom_word = 16'h120C;
`else
      3'd2: rom_word = 16'h1204;
`endif
      3'd3: rom_word = 16'h40D0;
      3'd4: rom_word = 16'h3A04;
      3'd5: rom_word = 16'h8C00;
`ifdef OV7670_QCIF_EN
      3'd6: rom_word = 16'h0C08;
`endif
      default: rom_word = 16'h0000;
    endcase
  end

  assign tick = (cnt == DIV_LAST);

  // Sequencing: the divider runs in the bit-timed states; WAIT reuses it as the soft-reset delay counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    qtr_nxt   = qtr;
    phase_nxt = phase;
    pos_nxt   = pos;
    entry_nxt = entry;
    case (state)
      IDLE, DONE: begin
        if (bus.go) begin
          state_nxt = START;
          entry_nxt = '0;
          cnt_nxt   = '0;
          qtr_nxt   = '0;
        end
      end
      WAIT: begin
        if (cnt == WAIT_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
          qtr_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        if (!tick) begin
          cnt_nxt = cnt + 1'b1;
        end else begin
          cnt_nxt = '0;
          qtr_nxt = qtr + 1'b1;
          if (qtr == 2'd3) begin
            case (state)
              START: begin
                state_nxt = BITS;
                phase_nxt = '0;
                pos_nxt   = '0;
              end
              BITS: begin
                if (pos == 4'd8) begin
                  pos_nxt = '0;
                  if (phase == 2'd2) state_nxt = STOP;
                  else               phase_nxt = phase + 1'b1;
                end else begin
                  pos_nxt = pos + 1'b1;
                end
              end
              STOP: state_nxt = (entry == 3'd0) ? WAIT : GAP;
              GAP: begin
                if (entry == LAST_ENTRY) begin
                  state_nxt = DONE;
                end else begin
                  entry_nxt = entry + 1'b1;
                  state_nxt = START;
                end
              end
              default: state_nxt = IDLE;
            endcase
          end
        end
      end
    endcase
  end

  // Line levels are decoded from the next state so the registered outputs move exactly with the quarter.
  always_comb begin
    cur_byte  = (phase_nxt == 2'd0) ? SLAVE_ID :
                (phase_nxt == 2'd1) ? rom_word[15:8] : rom_word[7:0];
    bit_sel   = 3'(4'd7 - pos_nxt);
    sio_c_nxt = 1'b1;
    oe_nxt    = 1'b0;
    case (state_nxt)
      START: begin
        sio_c_nxt = (qtr_nxt != 2'd3);
        oe_nxt    = (qtr_nxt != 2'd0);
      end
      BITS: begin
        sio_c_nxt = qtr_nxt[1];
        oe_nxt    = (pos_nxt != 4'd8) && !cur_byte[bit_sel];
      end
      STOP: begin
        sio_c_nxt = (qtr_nxt != 2'd0);
        oe_nxt    = (qtr_nxt != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_24) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      qtr     <= '0;
      phase   <= '0;
      pos     <= '0;
      entry   <= '0;
      sio_c_q <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      qtr     <= qtr_nxt;
      phase   <= phase_nxt;
      pos     <= pos_nxt;
      entry   <= entry_nxt;
      sio_c_q <= sio_c_nxt;
      oe_q    <= oe_nxt;
      busy_q  <= (state_nxt != IDLE) && (state_nxt != DONE);
      done_q  <= (state_nxt == DONE);
    end
  end

  assign bus.sio_c    = sio_c_q;
  assign bus.sio_d_oe = oe_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Directed bench for ov7670_sccb_config: decodes the SCCB lines and checks the writes, their timing and go/reset handling.
// Build with OV7670_QCIF_EN defined to check the QCIF table.
module tb_ov7670_sccb_config;
  localparam int CLK_DIV    = 8;
  localparam int RESET_WAIT = 500;
`ifdef OV7670_QCIF_EN
  localparam int NUM_ENTRIES = 7;
`else
  localparam int NUM_ENTRIES = 6;
`endif

  logic clk_24 = 1'b0;
  logic reset;
  int   cyc = 0;
  int   num_checks = 0;
  int   num_errors = 0;

  ov7670_sccb_config_if bus();

  ov7670_sccb_config #(
    .CLK_DIV    (CLK_DIV),
    .SLAVE_ID   (8'h42),
    .RESET_WAIT (RESET_WAIT)
  ) dut (
    .clk_24 (clk_24),
    .reset  (reset),
    .bus    (bus.master)
  );

  always #5 clk_24 = ~clk_24;

  always @(posedge clk_24) cyc <= cyc + 1;

  // Expected write table, entry by entry: {sub-addr, data}.
  function automatic logic [15:0] exp_word(input int idx);
    case (idx)
      0: exp_word = 16'h1280;
      1: exp_word = 16'h1101;
`ifdef OV7670_QCIF_EN
      2: exp_word = 16'h120C;
`else
      2: exp_word = 16'h1204;
`endif
      3: exp_word = 16'h40D0;
      4: exp_word = 16'h3A04;
      5: exp_word = 16'h8C00;
      6: exp_word = 16'h0C08;
      default: exp_word = 16'hxxxx;
    endcase
  endfunction

  // SCCB line decoder: START/STOP on SDA edges while SCL is high, data sampled on SCL rising edges.
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  logic        scl, sda;
  logic        in_tx = 1'b0;
  int          bit_cnt = 0;
  logic [26:0] shreg = '0;
  int          n_tx = 0;
  int          first_event = 0;
  int          start_cyc [32];
  int          stop_cyc  [32];
  logic [7:0]  log_id    [32];
  logic [7:0]  log_addr  [32];
  logic [7:0]  log_data  [32];

  always @(negedge clk_24) begin
    scl = bus.sio_c;
    sda = !bus.sio_d_oe;
    if (prev_scl === 1'b1 && scl === 1'b1 && prev_sda === 1'b1 && sda === 1'b0) begin
      in_tx   = 1'b1;
      bit_cnt = 0;
      shreg   = '0;
      if (n_tx < 32) start_cyc[n_tx] = cyc;
      if (first_event == 0) first_event = 1;
    end else if (prev_scl === 1'b1 && scl === 1'b1 && prev_sda === 1'b0 && sda === 1'b1) begin
      if (in_tx && bit_cnt == 27 && n_tx < 32) begin
        log_id[n_tx]   = shreg[26:19];
        log_addr[n_tx] = shreg[17:10];
        log_data[n_tx] = shreg[8:1];
        stop_cyc[n_tx] = cyc;
        n_tx++;
      end
      in_tx = 1'b0;
    end else if (prev_scl === 1'b0 && scl === 1'b1) begin
      if (in_tx && bit_cnt < 27) begin
        shreg = {shreg[25:0], sda};
        bit_cnt++;
      end
    end
    if (first_event == 0 && (scl !== prev_scl || sda !== prev_sda)) first_event = 2;
    prev_scl = scl;
    prev_sda = sda;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive go/reset for one clock, starting and ending on a falling edge.
  task automatic applyStimulus(input logic go_val, input logic reset_val);
    bus.go = go_val;
    reset  = reset_val;
    @(negedge clk_24);
    bus.go = 1'b0;
    reset  = 1'b0;
  endtask

  task automatic waitForDone(output int done_at);
    int n;
    n = 0;
    done_at = -1;
    while (bus.done !== 1'b1 && n < 20000) begin
      @(negedge clk_24);
      n++;
    end
    checkOutput("done_reached", bus.done, 1);
    if (bus.done === 1'b1) begin
      done_at = cyc;
      checkOutput("busy_low_at_done", bus.busy, 0);
    end
  endtask

  task automatic checkRun(input string tag, input int base_idx);
    checkOutput($sformatf("%s_count", tag), n_tx - base_idx, NUM_ENTRIES);
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      logic [15:0] w;
      w = exp_word(i);
      checkOutput($sformatf("%s_id%0d", tag, i), log_id[base_idx + i], 8'h42);
      checkOutput($sformatf("%s_addr%0d", tag, i), log_addr[base_idx + i], w[15:8]);
      checkOutput($sformatf("%s_data%0d", tag, i), log_data[base_idx + i], w[7:0]);
    end
  endtask

  int   base;
  int   go_cyc;
  int   done_at;
  int   n;
  logic bad_hold;

  initial begin
    reset  = 1'b1;
    bus.go = 1'b0;
    repeat (3) @(negedge clk_24);
    checkOutput("rst_sio_c", bus.sio_c, 1);
    checkOutput("rst_oe", bus.sio_d_oe, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    reset = 1'b0;
    @(negedge clk_24);

    $display("[TB] run 1: full sequence with a stray go while busy");
    base = n_tx;
    applyStimulus(1'b1, 1'b0);
    go_cyc = cyc;
    checkOutput("busy_after_go", bus.busy, 1);
    checkOutput("start_q0_lines", {bus.sio_c, bus.sio_d_oe}, 2'b10);
    repeat (CLK_DIV + 4) @(negedge clk_24);
    checkOutput("first_event_is_start", first_event, 1);
    checkOutput("start_offset", start_cyc[base] - go_cyc, CLK_DIV);
    repeat (40) @(negedge clk_24);
    applyStimulus(1'b1, 1'b0);
    checkOutput("busy_kept", bus.busy, 1);
    waitForDone(done_at);
    checkRun("run1", base);
    checkOutput("tx_length", stop_cyc[base] - start_cyc[base], 114 * CLK_DIV);
    checkOutput("gap_after_com7", start_cyc[base + 1] - stop_cyc[base], RESET_WAIT + 6 * CLK_DIV);
    checkOutput("gap_normal", start_cyc[base + 2] - stop_cyc[base + 1], 6 * CLK_DIV);
    checkOutput("done_delay", done_at - stop_cyc[base + NUM_ENTRIES - 1], 5 * CLK_DIV);

    bad_hold = 1'b0;
    repeat (10000) begin
      @(negedge clk_24);
      if (bus.done !== 1'b1 || bus.sio_c !== 1'b1 || bus.sio_d_oe !== 1'b0) bad_hold = 1'b1;
    end
    checkOutput("done_hold_idle", bad_hold, 0);

    $display("[TB] run 2: go while done restarts");
    base = n_tx;
    applyStimulus(1'b1, 1'b0);
    checkOutput("done_cleared_by_go", bus.done, 0);
    checkOutput("busy_restart", bus.busy, 1);
    waitForDone(done_at);
    checkRun("run2", base);

    $display("[TB] run 3: reset during data byte of entry 3");
    base = n_tx;
    applyStimulus(1'b1, 1'b0);
    n = 0;
    while (!(n_tx == base + 3 && in_tx && bit_cnt == 20) && n < 20000) begin
      @(negedge clk_24);
      n++;
    end
    checkOutput("reached_entry3_data", (n_tx == base + 3 && bit_cnt == 20) ? 1 : 0, 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("abort_lines", {bus.sio_c, bus.sio_d_oe}, 2'b10);
    checkOutput("abort_done", bus.done, 0);
    checkOutput("abort_busy", bus.busy, 0);
    repeat (100) @(negedge clk_24);
    checkOutput("abort_no_extra_write", n_tx - base, 3);

    applyStimulus(1'b1, 1'b1);
    checkOutput("go_with_reset_busy", bus.busy, 0);
    repeat (2 * CLK_DIV) @(negedge clk_24);
    checkOutput("go_with_reset_idle", {bus.sio_c, bus.sio_d_oe, bus.busy}, 3'b100);

    base = n_tx;
    applyStimulus(1'b1, 1'b0);
    waitForDone(done_at);
    checkRun("replay", base);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
